// File: rtl/ham_pkg.sv
// Shared definitions for the bit-serial Hamming-distance engine.
//   ham_state_t : engine FSM states (IDLE, SHIFT, DONE)
//   cnt_width() : width needed to hold a count of 0..width inclusive
package ham_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ham_state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/xor_bit_cell.sv
// Single-bit XOR built only from 2-input NAND gates (four-NAND form).
//   a, b : input bits
//   y    : a ^ b
module xor_bit_cell (
  input  logic a,
  input  logic b,
  output logic y
);

  logic n_ab;
  logic n_a;
  logic n_b;

  assign n_ab = ~(a & b);
  assign n_a  = ~(a & n_ab);
  assign n_b  = ~(b & n_ab);
  assign y    = ~(n_a & n_b);

endmodule

// File: rtl/serial_hamming_unit.sv
// Bit-serial Hamming-distance engine. An operand pair is accepted over a
// valid/ready handshake, streamed LSB-first through one NAND-built XOR cell,
// and the number of differing bits is returned over a second handshake.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake, in_a/in_b are WIDTH bits
//   out_valid/out_ready : result handshake
//   out_dist            : Hamming distance (CNT_W bits), held after release
//   out_equal           : high with out_valid when the distance is zero
//   busy                : high while shifting or presenting a result
module serial_hamming_unit
  import ham_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_dist,
  output logic             out_equal,
  output logic             busy
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  ham_state_t       state_q;
  ham_state_t       state_d;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] acc_sum;
  logic [CNT_W-1:0] dist_q;
  logic             diff_bit;
  logic             load;
  logic             finish;

  xor_bit_cell u_xor (
    .a (a_sh[0]),
    .b (b_sh[0]),
    .y (diff_bit)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    finish  = 1'b0;
    acc_sum = acc + CNT_W'(diff_bit);
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (idx == IDX_W'(WIDTH - 1)) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The final bit is folded into the result register on the same edge that
  // leaves SHIFT, so the distance is already complete on entry to DONE and
  // stays put after the result handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      idx     <= '0;
      acc     <= '0;
      dist_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        a_sh <= in_a;
        b_sh <= in_b;
        acc  <= '0;
        idx  <= '0;
      end else if (state_q == SHIFT) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        acc  <= acc_sum;
        idx  <= idx + IDX_W'(1);
      end
      if (finish) dist_q <= acc_sum;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == SHIFT) || (state_q == DONE);
  assign out_dist  = dist_q;
  assign out_equal = (state_q == DONE) && (dist_q == '0);

endmodule
